lut_mac_ctrl_module: RTL

Dot-product sequencer that wraps the LUT multiplier: accepts a stream of signed 8-bit operand pairs over a valid/ready handshake, drives the multiplier's start/done protocol one pair at a time, and accumulates the signed 16-bit products into a wide accumulator. After `LEN` pairs it emits the dot product with a one-cycle valid pulse. It sits between the sample source (upstream) and the LUT multiplier (downstream), and owns all of the multiplier's control inputs.

---
 rtl/lut_mac_ctrl_module.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/lut_mac_ctrl_module.sv
// Dot-product sequencer around the LUT multiplier: one operand pair per multiply, LEN pairs per result.
// Optional build macro LUT_MAC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module lut_mac_ctrl_module #(
  parameter int LEN   = 8,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             mul_start,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic             mul_done,
  input  logic [15:0]      mul_product,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_overflow,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  logic [1:0]              state_q, state_d;
  logic                    mul_start_q, mul_start_d;
  logic [7:0]              mul_a_q, mul_a_d;
  logic [7:0]              mul_b_q, mul_b_d;
  logic signed [15:0]      prod_q, prod_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] out_acc_q, out_acc_d;
  logic                    out_ovf_q, out_ovf_d;
  logic                    out_valid_q, out_valid_d;

  logic signed [ACC_W-1:0] addend, sum, acc_next;
  logic                    ovf_add;

  // Signed overflow: operands share a sign that the wrapped sum does not.
  function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                   input logic signed [ACC_W-1:0] b,
                                   input logic signed [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

`ifdef LUT_MAC_SATURATE_EN
  function automatic logic signed [ACC_W-1:0] sat_limit(input logic neg);
    return neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  endfunction
`endif

  assign addend  = ACC_W'(prod_q);
  assign sum     = acc_q + addend;
  assign ovf_add = add_ovf(acc_q, addend, sum);

  // On overflow both operands carry the true sum's sign.
`ifdef LUT_MAC_SATURATE_EN
  assign acc_next = ovf_add ? sat_limit(addend[ACC_W-1]) : sum;
`else
  assign acc_next = sum;
`endif

  always_comb begin
    state_d     = state_q;
    mul_start_d = mul_start_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    out_acc_d   = out_acc_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mul_a_d     = in_a;
          mul_b_d     = in_b;
          mul_start_d = 1'b1;
          state_d     = S_MUL;
        end
      end
      S_MUL: begin
        if (mul_done) begin
          prod_d      = mul_product;
          mul_start_d = 1'b0;
          state_d     = S_ACC;
        end
      end
      S_ACC: begin
        acc_d = acc_next;
        ovf_d = ovf_q | ovf_add;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          out_acc_d   = acc_next;
          out_ovf_d   = ovf_q | ovf_add;
          acc_d       = '0;
          ovf_d       = 1'b0;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_acc_q   <= out_acc_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Product capture is pure data and is only read after a fresh mul_done.
  always_ff @(posedge clk) begin
    prod_q <= prod_d;
  end

  assign in_ready     = (state_q == S_IDLE) && !rst;
  assign busy         = (state_q != S_IDLE);
  assign mul_start    = mul_start_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign out_valid    = out_valid_q;
  assign out_acc      = out_acc_q;
  assign out_overflow = out_ovf_q;

endmodule
